// File: rtl/display_pkg.sv
// Shared types and helpers for the display line-buffer unpacker.
package display_pkg;

   localparam int LB_ADDR_BITS = 10;
   localparam int LB_HALF_BIT  = 9;

   typedef enum logic [1:0] {
      PIX8  = 2'd0,
      PIX16 = 2'd1,
      PIX32 = 2'd2
   } pix_size_t;

   function automatic pix_size_t decode_pix_size(input logic [2:0] pixel_bytes);
      case (pixel_bytes)
         3'd4:    return PIX32;
         3'd2:    return PIX16;
         default: return PIX8;
      endcase
   endfunction

   // log2 of bytes per pixel
   function automatic logic [1:0] bytes_to_shift(input pix_size_t size);
      case (size)
         PIX32:   return 2'd2;
         PIX16:   return 2'd1;
         default: return 2'd0;
      endcase
   endfunction

   function automatic logic [5:0] pixels_per_word(input logic [5:0] word_bytes, input pix_size_t size);
      return word_bytes >> bytes_to_shift(size);
   endfunction

endpackage

// File: rtl/display_lbuf_ram.sv
// Line-buffer storage: one write port, one registered read port, 1-cycle read latency.
module display_lbuf_ram #(
   parameter int ADDR_BITS  = 10,
   parameter int DATA_WIDTH = 128
) (
   input  logic                  CMD_CLK,
   input  logic                  wr_en,
   input  logic [ADDR_BITS-1:0]  wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_BITS-1:0]  rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_BITS)-1];

   always_ff @(posedge CMD_CLK) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/display_lbuf_unpack.sv
// Writes returned DDR3 read words into a 2-half line buffer and unpacks one half
// into a 1-pixel-per-cycle valid/ready stream; tracks outstanding reads.
//
// state | meaning
// IDLE  | waiting for line_start
// LOAD  | two-cycle fetch of word 0 (and word 1 into the RAM output register)
// RUN   | streaming pixels; RAM output register holds the prefetched next word
module display_lbuf_unpack
   import display_pkg::*;
#(
   parameter int PORT_VECTOR_SIZE  = 12,
   parameter int PORT_R_DATA_WIDTH = 128,
   parameter int LB_HALF_WORDS     = 512,
   parameter int OUTST_BITS        = 8
) (
   input  logic                         CMD_CLK,
   input  logic                         reset,
   input  logic                         read_req_in,
   input  logic                         read_ready_in,
   input  logic [PORT_R_DATA_WIDTH-1:0] read_data_in,
   input  logic [PORT_VECTOR_SIZE-1:0]  read_vector_in,
   input  logic                         line_start,
   input  logic                         line_half,
   input  logic [13:0]                  line_pixels,
   input  logic [4:0]                   line_pix_offset,
   input  logic [2:0]                   DISP_pixel_bytes,
   output logic                         pix_valid,
   input  logic                         pix_ready,
   output logic [31:0]                  pix_data,
   output logic                         line_done,
   output logic [OUTST_BITS-1:0]        outstanding,
   output logic                         late_err,
   output logic                         cnt_err
);

   localparam int DW_BITS = $clog2(PORT_R_DATA_WIDTH);
   localparam logic [5:0] WORD_BYTES = 6'(PORT_R_DATA_WIDTH / 8);

   if ((PORT_R_DATA_WIDTH != 128 && PORT_R_DATA_WIDTH != 256) ||
       LB_HALF_WORDS != (1 << LB_HALF_BIT)) begin : g_bad_cfg
      $error("display_lbuf_unpack: unsupported word width or half size");
   end

   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

   state_t                   state;
   logic                     load_ph;
   logic                     half_l;
   pix_size_t                size_l;
   logic [4:0]               ppw_m1;
   logic [4:0]               idx;
   logic [13:0]              remaining;
   logic [LB_HALF_BIT-1:0]   word_idx;
   logic [PORT_R_DATA_WIDTH-1:0] cur_word;
   logic [PORT_R_DATA_WIDTH-1:0] nxt_word;

   pix_size_t  start_size;
   logic [5:0] start_ppw;
   logic [4:0] start_ppw_m1;
   logic [4:0] start_off;
   logic       unused_vec_bits;

   assign start_size      = decode_pix_size(DISP_pixel_bytes);
   assign start_ppw       = pixels_per_word(WORD_BYTES, start_size);
   assign start_ppw_m1    = 5'(start_ppw - 6'd1);
   assign start_off       = line_pix_offset & start_ppw_m1;
   assign unused_vec_bits = ^read_vector_in[PORT_VECTOR_SIZE-1:LB_ADDR_BITS];

   function automatic logic [31:0] sel_pixel(input logic [PORT_R_DATA_WIDTH-1:0] word,
                                             input logic [4:0] p, input pix_size_t size);
      logic [31:0]        px;
      logic [DW_BITS-1:0] base;
      px   = '0;
      base = '0;
      case (size)
         PIX32: begin
            base = DW_BITS'({p, 5'd0});
            px   = word[base +: 32];
         end
         PIX16: begin
            base      = DW_BITS'({p, 4'd0});
            px[15:0]  = word[base +: 16];
         end
         default: begin
            base     = DW_BITS'({p, 3'd0});
            px[7:0]  = word[base +: 8];
         end
      endcase
      return px;
   endfunction

   // nxt_word is the RAM's output register; word_idx always points at the word after cur_word
   display_lbuf_ram #(
      .ADDR_BITS  (LB_ADDR_BITS),
      .DATA_WIDTH (PORT_R_DATA_WIDTH)
   ) u_ram (
      .CMD_CLK (CMD_CLK),
      .wr_en   (read_ready_in),
      .wr_addr (read_vector_in[LB_ADDR_BITS-1:0]),
      .wr_data (read_data_in),
      .rd_addr ({half_l, word_idx}),
      .rd_data (nxt_word)
   );

   always_ff @(posedge CMD_CLK or posedge reset) begin
      if (reset) begin
         outstanding <= '0;
         late_err    <= 1'b0;
         cnt_err     <= 1'b0;
      end else begin
         case ({read_req_in, read_ready_in})
            2'b10: if (outstanding != '1) outstanding <= outstanding + 1'b1;
            2'b01: begin
               if (outstanding == '0) cnt_err <= 1'b1;
               else                   outstanding <= outstanding - 1'b1;
            end
            default: ;
         endcase
         if (line_start && outstanding != '0) late_err <= 1'b1;
      end
   end

   always_ff @(posedge CMD_CLK or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         load_ph   <= 1'b0;
         half_l    <= 1'b0;
         size_l    <= PIX8;
         ppw_m1    <= '0;
         idx       <= '0;
         remaining <= '0;
         word_idx  <= '0;
         cur_word  <= '0;
         pix_valid <= 1'b0;
         pix_data  <= '0;
         line_done <= 1'b0;
      end else begin
         line_done <= 1'b0;
         // line_start from any state (re)starts, which also covers abort
         if (line_start) begin
            pix_valid <= 1'b0;
            if (line_pixels == '0) begin
               line_done <= 1'b1;
               state     <= IDLE;
            end else begin
               half_l    <= line_half;
               size_l    <= start_size;
               ppw_m1    <= start_ppw_m1;
               idx       <= start_off;
               remaining <= line_pixels;
               word_idx  <= '0;
               load_ph   <= 1'b0;
               state     <= LOAD;
            end
         end else begin
            case (state)
               LOAD: begin
                  if (!load_ph) begin
                     load_ph  <= 1'b1;
                     word_idx <= word_idx + 1'b1;
                  end else begin
                     cur_word  <= nxt_word;
                     pix_data  <= sel_pixel(nxt_word, idx, size_l);
                     pix_valid <= 1'b1;
                     state     <= RUN;
                  end
               end
               RUN: begin
                  if (pix_ready) begin
                     if (remaining == 14'd1) begin
                        pix_valid <= 1'b0;
                        line_done <= 1'b1;
                        state     <= IDLE;
                     end else begin
                        remaining <= remaining - 1'b1;
                        if (idx == ppw_m1) begin
                           idx      <= '0;
                           cur_word <= nxt_word;
                           pix_data <= sel_pixel(nxt_word, 5'd0, size_l);
                           word_idx <= word_idx + 1'b1;
                        end else begin
                           idx      <= idx + 5'd1;
                           pix_data <= sel_pixel(cur_word, idx + 5'd1, size_l);
                        end
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_display_lbuf_unpack.sv
// Directed bench for display_lbuf_unpack with an expected-pixel queue.
module tb_display_lbuf_unpack;

   logic         CMD_CLK = 1'b0;
   logic         reset;
   logic         read_req_in;
   logic         read_ready_in;
   logic [127:0] read_data_in;
   logic [11:0]  read_vector_in;
   logic         line_start;
   logic         line_half;
   logic [13:0]  line_pixels;
   logic [4:0]   line_pix_offset;
   logic [2:0]   DISP_pixel_bytes;
   logic         pix_valid;
   logic         pix_ready;
   logic [31:0]  pix_data;
   logic         line_done;
   logic [7:0]   outstanding;
   logic         late_err;
   logic         cnt_err;

   display_lbuf_unpack dut (
      .CMD_CLK          (CMD_CLK),
      .reset            (reset),
      .read_req_in      (read_req_in),
      .read_ready_in    (read_ready_in),
      .read_data_in     (read_data_in),
      .read_vector_in   (read_vector_in),
      .line_start       (line_start),
      .line_half        (line_half),
      .line_pixels      (line_pixels),
      .line_pix_offset  (line_pix_offset),
      .DISP_pixel_bytes (DISP_pixel_bytes),
      .pix_valid        (pix_valid),
      .pix_ready        (pix_ready),
      .pix_data         (pix_data),
      .line_done        (line_done),
      .outstanding      (outstanding),
      .late_err         (late_err),
      .cnt_err          (cnt_err)
   );

   always #5 CMD_CLK = ~CMD_CLK;

   int          vectors     = 0;
   int          miscompares = 0;
   int          done_cnt    = 0;
   logic [31:0] exp_q[$];
   logic        stall_prev  = 1'b0;
   logic [31:0] held        = '0;
   bit          ready_toggle = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge with inputs already driven; advances to the next negedge.
   task automatic cyc();
      if (pix_valid && pix_ready && !line_start && !reset) begin
         vectors++;
         assert (exp_q.size() != 0) else begin
            miscompares++;
            $error("FAIL extra_pixel: observed %0h expected none", pix_data);
         end
         if (exp_q.size() != 0) chk("pixel", pix_data, exp_q.pop_front());
      end
      if (stall_prev && pix_valid) chk("stall_hold", pix_data, held);
      stall_prev = pix_valid && !pix_ready && !line_start && !reset;
      held = pix_data;
      @(negedge CMD_CLK);
      if (line_done) done_cnt++;
   endtask

   task automatic wr_word(input logic [9:0] addr, input logic [127:0] data);
      read_req_in    = 1'b1;
      read_ready_in  = 1'b1;
      read_vector_in = {2'b00, addr};
      read_data_in   = data;
      cyc();
      read_req_in    = 1'b0;
      read_ready_in  = 1'b0;
   endtask

   task automatic start_line(input logic half, input int pixels, input int off, input logic [2:0] bytes);
      line_start       = 1'b1;
      line_half        = half;
      line_pixels      = 14'(pixels);
      line_pix_offset  = 5'(off);
      DISP_pixel_bytes = bytes;
      cyc();
      line_start       = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 1;
      while (!pix_valid && lat < 12) begin
         cyc();
         lat++;
      end
   endtask

   task automatic wait_done(output int n);
      int d0;
      d0 = done_cnt;
      n  = 0;
      while (done_cnt == d0 && n < 200) begin
         pix_ready = ready_toggle ? ((n % 4 == 0) || (n % 4 == 3)) : 1'b1;
         cyc();
         n++;
      end
      pix_ready = 1'b1;
   endtask

   task automatic run_line(input logic half, input int pixels, input int off, input logic [2:0] bytes,
                           output int lat, output int n);
      start_line(half, pixels, off, bytes);
      wait_valid(lat);
      wait_done(n);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, n, d0;
      logic [127:0] w;

      reset = 1'b1;
      read_req_in = 1'b0; read_ready_in = 1'b0; read_data_in = '0; read_vector_in = '0;
      line_start = 1'b0; line_half = 1'b0; line_pixels = '0; line_pix_offset = '0;
      DISP_pixel_bytes = '0; pix_ready = 1'b1;
      repeat (3) @(negedge CMD_CLK);

      chk("rst_pix_valid", 32'(pix_valid), 32'd0);
      chk("rst_pix_data", pix_data, 32'd0);
      chk("rst_line_done", 32'(line_done), 32'd0);
      chk("rst_outstanding", 32'(outstanding), 32'd0);
      chk("rst_late_err", 32'(late_err), 32'd0);
      chk("rst_cnt_err", 32'(cnt_err), 32'd0);
      reset = 1'b0;
      cyc();

      // 32-bit pixels, words 0 and 1
      wr_word(10'd0, {32'd3, 32'd2, 32'd1, 32'd0});
      wr_word(10'd1, {32'd7, 32'd6, 32'd5, 32'd4});
      for (int i = 0; i < 8; i++) exp_q.push_back(32'(i));
      d0 = done_cnt;
      run_line(1'b0, 8, 0, 3'd4, lat, n);
      chk("t32_latency", 32'(lat), 32'd3);
      chk("t32_cycles_to_done", 32'(n), 32'd8);
      chk("t32_queue_left", 32'(exp_q.size()), 32'd0);
      chk("t32_done_count", 32'(done_cnt - d0), 32'd1);
      chk("t32_valid_after", 32'(pix_valid), 32'd0);
      chk("t32_late_err", 32'(late_err), 32'd0);

      // 8-bit pixels, upper half, offset 13 crossing a word edge
      for (int i = 0; i < 16; i++) w[i*8 +: 8] = 8'(i);
      wr_word(10'd512, w);
      for (int i = 0; i < 16; i++) w[i*8 +: 8] = 8'(16 + i);
      wr_word(10'd513, w);
      for (int i = 13; i < 19; i++) exp_q.push_back(32'(i));
      run_line(1'b1, 6, 13, 3'd1, lat, n);
      chk("t8_latency", 32'(lat), 32'd3);
      chk("t8_cycles_to_done", 32'(n), 32'd6);
      chk("t8_queue_left", 32'(exp_q.size()), 32'd0);

      // zero-length line: immediate done pulse, no pixels
      d0 = done_cnt;
      start_line(1'b0, 0, 0, 3'd4);
      chk("zero_done", 32'(done_cnt - d0), 32'd1);
      cyc(); cyc(); cyc();
      chk("zero_no_valid", 32'(pix_valid), 32'd0);
      chk("zero_done_once", 32'(done_cnt - d0), 32'd1);

      // 16-bit pixels with ready pattern 1,0,0,1
      for (int wd = 0; wd < 3; wd++) begin
         for (int k = 0; k < 8; k++) w[k*16 +: 16] = 16'(16'h1000 + wd*8 + k);
         wr_word(10'(wd), w);
      end
      for (int i = 0; i < 24; i++) exp_q.push_back(32'(16'h1000 + i));
      ready_toggle = 1'b1;
      d0 = done_cnt;
      run_line(1'b0, 24, 0, 3'd2, lat, n);
      ready_toggle = 1'b0;
      chk("t16_latency", 32'(lat), 32'd3);
      chk("t16_cycles_to_done", 32'(n), 32'd48);
      chk("t16_queue_left", 32'(exp_q.size()), 32'd0);
      chk("t16_done_count", 32'(done_cnt - d0), 32'd1);

      // outstanding counter
      read_vector_in = 12'd1023;
      read_req_in = 1'b1;
      repeat (3) cyc();
      read_req_in = 1'b0;
      chk("outst_after_req", 32'(outstanding), 32'd3);
      read_req_in = 1'b1; read_ready_in = 1'b1;
      cyc();
      read_req_in = 1'b0; read_ready_in = 1'b0;
      chk("outst_both", 32'(outstanding), 32'd3);
      read_ready_in = 1'b1;
      repeat (3) cyc();
      read_ready_in = 1'b0;
      chk("outst_drained", 32'(outstanding), 32'd0);
      chk("cnt_err_clear", 32'(cnt_err), 32'd0);
      read_ready_in = 1'b1;
      cyc();
      read_ready_in = 1'b0;
      chk("cnt_err_set", 32'(cnt_err), 32'd1);
      chk("outst_floor", 32'(outstanding), 32'd0);

      // late line start, then abort mid-RUN
      read_req_in = 1'b1;
      repeat (2) cyc();
      read_req_in = 1'b0;
      chk("outst_two", 32'(outstanding), 32'd2);
      for (int i = 0; i < 20; i++) exp_q.push_back(32'(i));
      d0 = done_cnt;
      start_line(1'b1, 20, 0, 3'd1);
      chk("late_err_set", 32'(late_err), 32'd1);
      wait_valid(lat);
      chk("late_latency", 32'(lat), 32'd3);
      pix_ready = 1'b1;
      repeat (5) cyc();
      chk("pre_abort_popped", 32'(exp_q.size()), 32'd15);
      pix_ready = 1'b0;
      exp_q.delete();
      for (int i = 2; i < 6; i++) exp_q.push_back(32'(i));
      start_line(1'b1, 4, 2, 3'd1);
      chk("abort_drop", 32'(pix_valid), 32'd0);
      wait_valid(lat);
      chk("abort_latency", 32'(lat), 32'd3);
      wait_done(n);
      chk("abort_cycles_to_done", 32'(n), 32'd4);
      chk("abort_done_count", 32'(done_cnt - d0), 32'd1);
      chk("abort_queue_left", 32'(exp_q.size()), 32'd0);

      // reset in the middle of a line
      for (int i = 0; i < 10; i++) exp_q.push_back(32'(i));
      start_line(1'b1, 10, 0, 3'd1);
      wait_valid(lat);
      pix_ready = 1'b1;
      repeat (2) cyc();
      reset = 1'b1;
      #1;
      chk("mid_rst_pix_valid", 32'(pix_valid), 32'd0);
      chk("mid_rst_pix_data", pix_data, 32'd0);
      chk("mid_rst_line_done", 32'(line_done), 32'd0);
      chk("mid_rst_outstanding", 32'(outstanding), 32'd0);
      chk("mid_rst_late_err", 32'(late_err), 32'd0);
      chk("mid_rst_cnt_err", 32'(cnt_err), 32'd0);
      exp_q.delete();
      stall_prev = 1'b0;
      @(negedge CMD_CLK);
      reset = 1'b0;
      cyc();
      for (int i = 0; i < 10; i++) exp_q.push_back(32'(i));
      d0 = done_cnt;
      run_line(1'b1, 10, 0, 3'd1, lat, n);
      chk("post_rst_latency", 32'(lat), 32'd3);
      chk("post_rst_cycles_to_done", 32'(n), 32'd10);
      chk("post_rst_queue_left", 32'(exp_q.size()), 32'd0);
      chk("post_rst_done_count", 32'(done_cnt - d0), 32'd1);
      chk("post_rst_late_err", 32'(late_err), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
